// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Holds the FSM state encoding, the zero-register index and the redirect address width.
// Imported by pipe_ctrl and hazard_detect.
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_INIT     = 2'd0;
  localparam logic [1:0] PC_RUN      = 2'd1;
  localparam logic [1:0] PC_MEM_WAIT = 2'd2;
  localparam logic [1:0] PC_ERR      = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int JUMP_ADDR_W = 64;

  typedef enum logic [1:0] {
    ST_INIT     = PC_INIT,
    ST_RUN      = PC_RUN,
    ST_MEM_WAIT = PC_MEM_WAIT,
    ST_ERR      = PC_ERR
  } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and the ID sources.
// Latency: 0 cycles (pure combinational).
// Ports: ex_is_load_i/ex_rd_i from EX, id_rs*_i/id_rs*_ren_i from ID, lu_o = load-use hazard.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_is_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_rs1_ren_i,
  input  logic       id_rs2_ren_i,
  output logic       lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_ren_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_ren_i && (id_rs2_i == ex_rd_i);

  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign lu_o = ex_is_load_i && (ex_rd_i != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hold/flush/redirect controller for the five-stage RV64 pipeline, with memory-wait watchdog.
// Latency: all controls combinational from state and inputs, effective at the next clk edge.
// Ports: hazard inputs (load-use, redirect, mem wait) -> hold_*/flush_*/jump_* outputs, mem_err_o,
//        stall_cnt_o/flush_cnt_o (live only when PIPE_PERF_EN is defined, else tied to 0).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_is_load_i,
  input  logic [4:0]             ex_rd_i,
  input  logic [4:0]             id_rs1_i,
  input  logic [4:0]             id_rs2_i,
  input  logic                   id_rs1_ren_i,
  input  logic                   id_rs2_ren_i,
  input  logic                   jump_en_i,
  input  logic [JUMP_ADDR_W-1:0] jump_addr_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ready_i,
  output logic                   hold_pc_o,
  output logic                   hold_if_id_o,
  output logic                   hold_id_ex_o,
  output logic                   hold_ex_mem_o,
  output logic                   flush_if_id_o,
  output logic                   flush_id_ex_o,
  output logic                   flush_ex_mem_o,
  output logic                   flush_mem_wb_o,
  output logic                   jump_en_o,
  output logic [JUMP_ADDR_W-1:0] jump_addr_o,
  output logic                   mem_err_o,
  output logic [CNT_W-1:0]       stall_cnt_o,
  output logic [CNT_W-1:0]       flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;

  logic lu;
  logic mw;
  logic run_eval;

  logic hold_pc_c, hold_if_id_c, hold_id_ex_c, hold_ex_mem_c;
  logic flush_if_id_c, flush_id_ex_c, flush_ex_mem_c, flush_mem_wb_c;
  logic jump_en_c;

  hazard_detect u_hazard_detect (
    .ex_is_load_i (ex_is_load_i),
    .ex_rd_i      (ex_rd_i),
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_ren_i (id_rs1_ren_i),
    .id_rs2_ren_i (id_rs2_ren_i),
    .lu_o         (lu)
  );

  assign mw       = mem_req_i && !mem_ready_i;
  assign wait_inc = wait_q + WAIT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_d         = wait_q;
    run_eval       = 1'b0;
    hold_pc_c      = 1'b0;
    hold_if_id_c   = 1'b0;
    hold_id_ex_c   = 1'b0;
    hold_ex_mem_c  = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    flush_ex_mem_c = 1'b0;
    flush_mem_wb_c = 1'b0;
    jump_en_c      = 1'b0;

    case (state_q)
      ST_INIT: begin
        flush_if_id_c  = 1'b1;
        flush_id_ex_c  = 1'b1;
        flush_ex_mem_c = 1'b1;
        flush_mem_wb_c = 1'b1;
        wait_d         = '0;
        state_d        = ST_RUN;
      end
      ST_RUN: begin
        run_eval = 1'b1;
      end
      ST_MEM_WAIT: begin
        // The completing cycle behaves exactly like a RUN cycle.
        if (mem_ready_i) begin
          run_eval = 1'b1;
        end else begin
          hold_pc_c      = 1'b1;
          hold_if_id_c   = 1'b1;
          hold_id_ex_c   = 1'b1;
          hold_ex_mem_c  = 1'b1;
          flush_mem_wb_c = 1'b1;
          wait_d         = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ERR: begin
        hold_pc_c      = 1'b1;
        hold_if_id_c   = 1'b1;
        hold_id_ex_c   = 1'b1;
        hold_ex_mem_c  = 1'b1;
        flush_mem_wb_c = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (run_eval) begin
      wait_d  = '0;
      state_d = ST_RUN;
      if (mw) begin
        hold_pc_c      = 1'b1;
        hold_if_id_c   = 1'b1;
        hold_id_ex_c   = 1'b1;
        hold_ex_mem_c  = 1'b1;
        flush_mem_wb_c = 1'b1;
        state_d        = ST_MEM_WAIT;
      end else if (jump_en_i) begin
        // The instruction in ID is squashed, so any load-use against it is moot.
        jump_en_c     = 1'b1;
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
      end else if (lu) begin
        hold_pc_c     = 1'b1;
        hold_if_id_c  = 1'b1;
        flush_id_ex_c = 1'b1;
      end
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign hold_pc_o      = hold_pc_c      && !rst;
  assign hold_if_id_o   = hold_if_id_c   && !rst;
  assign hold_id_ex_o   = hold_id_ex_c   && !rst;
  assign hold_ex_mem_o  = hold_ex_mem_c  && !rst;
  assign flush_if_id_o  = flush_if_id_c  && !rst;
  assign flush_id_ex_o  = flush_id_ex_c  && !rst;
  assign flush_ex_mem_o = flush_ex_mem_c && !rst;
  assign flush_mem_wb_o = flush_mem_wb_c && !rst;
  assign jump_en_o      = jump_en_c      && !rst;
  assign jump_addr_o    = jump_en_o ? jump_addr_i : '0;
  assign mem_err_o      = (state_q == ST_ERR) && !rst;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hold_pc_o && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      // The INIT bubble is a reset artefact, not a pipeline flush.
      if ((flush_if_id_o || flush_id_ex_o) && (state_q != ST_INIT) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed sequence followed by random stimulus,
// every cycle compared against a cycle-level reference model of the controller rules.
module tb_pipe_ctrl;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i, id_rs1_i, id_rs2_i;
  logic        id_rs1_ren_i, id_rs2_ren_i;
  logic        jump_en_i;
  logic [63:0] jump_addr_i;
  logic        mem_req_i, mem_ready_i;
  logic        hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o;
  logic        flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o;
  logic        jump_en_o;
  logic [63:0] jump_addr_o;
  logic        mem_err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_init;
  bit          m_wait;
  bit          m_err;
  int          m_wait_n;
  logic [31:0] m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_i        (ex_rd_i),
    .id_rs1_i       (id_rs1_i),
    .id_rs2_i       (id_rs2_i),
    .id_rs1_ren_i   (id_rs1_ren_i),
    .id_rs2_ren_i   (id_rs2_ren_i),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .mem_req_i      (mem_req_i),
    .mem_ready_i    (mem_ready_i),
    .hold_pc_o      (hold_pc_o),
    .hold_if_id_o   (hold_if_id_o),
    .hold_id_ex_o   (hold_id_ex_o),
    .hold_ex_mem_o  (hold_ex_mem_o),
    .flush_if_id_o  (flush_if_id_o),
    .flush_id_ex_o  (flush_id_ex_o),
    .flush_ex_mem_o (flush_ex_mem_o),
    .flush_mem_wb_o (flush_mem_wb_o),
    .jump_en_o      (jump_en_o),
    .jump_addr_o    (jump_addr_o),
    .mem_err_o      (mem_err_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_is_load_i = 1'b0; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs2_i = 5'd0;
    id_rs1_ren_i = 1'b0; id_rs2_ren_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 64'd0;
    mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  // One clock cycle: called just after a negedge with inputs already driven.
  // Vector order: {hold pc,if_id,id_ex,ex_mem, flush if_id,id_ex,ex_mem,mem_wb, jump_en, mem_err}
  task automatic step(input string tag);
    logic        lu, stall, was_init;
    logic [9:0]  v, obs;
    logic [63:0] a;
    #1;
    v = '0; a = '0; stall = 1'b0;
    lu = ex_is_load_i && (ex_rd_i != 5'd0) &&
         ((id_rs1_ren_i && id_rs1_i == ex_rd_i) || (id_rs2_ren_i && id_rs2_i == ex_rd_i));
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end else if (m_init) begin
      v = 10'b0000_1111_0_0;
    end else if (m_err) begin
      v = 10'b1111_0001_0_1;
    end else begin
      stall = m_wait ? !mem_ready_i : (mem_req_i && !mem_ready_i);
      if (stall) v = 10'b1111_0001_0_0;
      else if (jump_en_i) begin v = 10'b0000_1100_1_0; a = jump_addr_i; end
      else if (lu) v = 10'b1100_0100_0_0;
    end
    obs = {hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
           flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o, jump_en_o, mem_err_o};
    chk({tag, "/ctrl"}, 64'(obs), 64'(v));
    chk({tag, "/addr"}, jump_addr_o, a);
`ifdef PIPE_PERF_EN
    chk({tag, "/stall_cnt"}, 64'(stall_cnt_o), 64'(m_stall));
    chk({tag, "/flush_cnt"}, 64'(flush_cnt_o), 64'(m_flush));
`else
    chk({tag, "/stall_cnt"}, 64'(stall_cnt_o), 64'd0);
    chk({tag, "/flush_cnt"}, 64'(flush_cnt_o), 64'd0);
`endif
    @(posedge clk);
    was_init = m_init;
    if (rst) begin
      m_init = 1'b1; m_wait = 1'b0; m_err = 1'b0; m_wait_n = 0;
      m_stall = '0; m_flush = '0;
    end else begin
      if (v[9] && m_stall != '1) m_stall++;
      if ((v[5] || v[4]) && !was_init && m_flush != '1) m_flush++;
      if (m_init) m_init = 1'b0;
      else if (!m_err) begin
        if (stall) begin
          if (m_wait) begin
            m_wait_n++;
            if (m_wait_n == TB_TIMEOUT) m_err = 1'b1;
          end else begin
            m_wait = 1'b1;
            m_wait_n = 0;
          end
        end else begin
          m_wait = 1'b0;
          m_wait_n = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_init = 1'b1; m_wait = 1'b0; m_err = 1'b0; m_wait_n = 0; m_stall = '0; m_flush = '0;
    @(negedge clk);

    // Reset held, then release: one INIT flush cycle then quiet.
    step("reset0");
    step("reset1");
    rst = 1'b0;
    step("init");
    step("idle");

    // Load-use on rs2, then same pattern with rd = x0.
    ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_ren_i = 1'b1;
    step("lu_rs2");
    ex_rd_i = 5'd0; id_rs2_i = 5'd0;
    step("lu_x0");
    idle_inputs();
    step("idle2");

    // Redirect with simultaneous load-use.
    ex_is_load_i = 1'b1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_ren_i = 1'b1;
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0040;
    step("jump_lu");
    idle_inputs();

    // Three-cycle memory wait with a pending redirect held throughout.
    jump_en_i = 1'b1; jump_addr_i = 64'h8000_0040; mem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) step("memwait_jump");
    mem_ready_i = 1'b1;
    step("memdone_jump");
    idle_inputs();
    step("idle3");

    // Counter scenario from a fresh reset: 3-cycle wait plus one load-use.
    rst = 1'b1;
    step("rst_perf");
    rst = 1'b0;
    step("init_perf");
    mem_req_i = 1'b1;
    for (int i = 0; i < 3; i++) step("perf_wait");
    mem_ready_i = 1'b1;
    step("perf_done");
    idle_inputs();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_rs1_ren_i = 1'b1;
    step("perf_lu");
    idle_inputs();
    step("perf_idle");
`ifdef PIPE_PERF_EN
    chk("perf_stall_total", 64'(stall_cnt_o), 64'd4);
    chk("perf_flush_total", 64'(flush_cnt_o), 64'd1);
`else
    chk("perf_stall_total", 64'(stall_cnt_o), 64'd0);
    chk("perf_flush_total", 64'(flush_cnt_o), 64'd0);
`endif

    // Watchdog: ready never comes; error is sticky until reset.
    mem_req_i = 1'b1;
    for (int i = 0; i < TB_TIMEOUT + 4; i++) step("timeout");
    mem_req_i = 1'b0; mem_ready_i = 1'b1;
    step("err_sticky");
    chk("err_flag", 64'(mem_err_o), 64'd1);
    idle_inputs();
    rst = 1'b1;
    step("err_rst");
    rst = 1'b0;
    step("err_init");
    step("err_cleared");

    // Ready arriving on the same cycle the wait count would expire.
    mem_req_i = 1'b1;
    for (int i = 0; i < TB_TIMEOUT; i++) step("edge_wait");
    mem_ready_i = 1'b1;
    step("edge_done");
    idle_inputs();
    step("edge_idle");

    // Reset asserted in the middle of a memory wait.
    mem_req_i = 1'b1;
    step("mid_wait0");
    step("mid_wait1");
    rst = 1'b1;
    step("mid_rst");
    idle_inputs();
    rst = 1'b0;
    step("mid_init");

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      ex_is_load_i = $urandom_range(0, 1);
      ex_rd_i      = 5'($urandom_range(0, 3));
      id_rs1_i     = 5'($urandom_range(0, 3));
      id_rs2_i     = 5'($urandom_range(0, 3));
      id_rs1_ren_i = $urandom_range(0, 1);
      id_rs2_ren_i = $urandom_range(0, 1);
      jump_en_i    = ($urandom_range(0, 5) == 0);
      jump_addr_i  = {$urandom, $urandom};
      mem_req_i    = ($urandom_range(0, 2) == 0);
      mem_ready_i  = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and sequencing controller for the five-stage RV64 core. It drives the hold and flush controls of the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three hazard sources: load-use data hazards, EX-stage redirects and multi-cycle data-memory waits. It includes a memory-wait watchdog and optional performance counters.

## Interface
- MEM_TIMEOUT, 255: max consecutive wait cycles before error (≥1)
- CNT_W, 32: perf counter width
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- ex_is_load_i  in  1  instruction in EX is a load
- ex_rd_i  in  5  EX destination register
- id_rs1_i, id_rs2_i  in  5 each  ID source registers
- id_rs1_ren_i, id_rs2_ren_i  in  1 each  ID source read enables
- jump_en_i  in  1  EX redirect request
- jump_addr_i  in  64  redirect target
- mem_req_i  in  1  MEM stage has an outstanding data access
- mem_ready_i  in  1  data memory completes the access this cycle
- hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o  out  1 each  freeze register
- flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out  1 each  load bubble (reset value) this edge
- jump_en_o  out  1  PC load enable for redirect
- jump_addr_o  out  64  PC redirect target
- mem_err_o  out  1  sticky watchdog error
- stall_cnt_o, flush_cnt_o  out  CNT_W each  perf counters

## Operation
- FSM states: INIT, RUN, MEM_WAIT, ERR. Reset enters INIT.
- INIT: all four flush outputs 1, all holds 0. Lasts one cycle, then RUN.
- Load-use hazard (LU): ex_is_load_i & ex_rd_i≠0 & ((id_rs1_ren_i & id_rs1_i==ex_rd_i) | (id_rs2_ren_i & id_rs2_i==ex_rd_i)).
- Memory wait (MW): mem_req_i & ~mem_ready_i.
- Priority in RUN: MW > redirect > LU.
  - MW: hold_pc, hold_if_id, hold_id_ex, hold_ex_mem = 1; flush_mem_wb = 1. Go to MEM_WAIT.
  - Redirect: jump_en_o=1, jump_addr_o=jump_addr_i, flush_if_id=1, flush_id_ex=1. LU is ignored because the younger instruction is squashed.
  - LU: hold_pc=1, hold_if_id=1, flush_id_ex=1 for the cycle.
- MEM_WAIT: same outputs as MW. jump_en_o is suppressed.
  - EX is frozen, so jump_en_i remains asserted and is serviced on the first RUN cycle.
  - Return to RUN on the cycle mem_ready_i=1. That cycle's outputs are evaluated as RUN, so LU or redirect may fire.
  - The wait counter increments each MEM_WAIT cycle. On reaching MEM_TIMEOUT, go to ERR.
- ERR: mem_err_o=1. All holds 1, flush_mem_wb=1, jump_en_o=0. Left only by reset.
- jump_addr_o equals jump_addr_i whenever jump_en_o=1, else 0.
- A hold and a flush are never both asserted on the same register.

## Timing
- All hold, flush and jump outputs are combinational from state and inputs, effective at the next clk edge. No added latency.
- Load-use costs exactly one bubble. A redirect costs two squashed instructions.
- While rst=1: all outputs 0, state=INIT, counters 0, wait counter 0.
- Wait counter clears on every entry to RUN.
- Reset asserted mid-MEM_WAIT: outputs drop to 0 asynchronously. The INIT flush follows reset release.
- A mem_ready_i on the same cycle as the wait counter reaching MEM_TIMEOUT completes the access: go to RUN, no error.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cnt_o increments on any cycle with hold_pc_o=1.
  - flush_cnt_o increments on any cycle with flush_if_id_o | flush_id_ex_o=1, excluding INIT.
  - Both counters saturate at all-ones and are cleared by reset.
- PIPE_PERF_EN undefined: ports remain and are tied to 0. No counter flops are inferred.

## Structure
- The shared defines package holds:
  - state encoding constants PC_INIT, PC_RUN, PC_MEM_WAIT, PC_ERR (2-bit);
  - the zero register index constant;
  - the redirect address width.
- One sub-module, hazard_detect: a purely combinational LU comparator that keeps the FSM file small.
- FSM, watchdog and counters live in pipe_ctrl.

## Test plan
- Reset release: exactly one cycle of all four flushes = 1, then all outputs 0 with idle inputs.
- ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_ren_i=1 → one cycle hold_pc=hold_if_id=flush_id_ex=1. With ex_rd_i=0 → no action.
- jump_en_i=1, jump_addr_i=0x8000_0040 with simultaneous LU → jump_en_o=1, jump_addr_o=0x8000_0040, flush_if_id=flush_id_ex=1, no holds.
- mem_req_i=1, mem_ready_i low for 3 cycles, then high → holds and flush_mem_wb for 3 cycles; RUN outputs on the 4th cycle. With jump_en_i high throughout, redirect fires only on the 4th cycle.
- MEM_TIMEOUT=4, mem_ready_i never asserted → ERR after 4 wait cycles, mem_err_o sticky; reset clears it.
- PIPE_PERF_EN: 3-cycle memory wait plus one LU → stall_cnt_o=4, flush_cnt_o=1. Without the macro, both read 0.
